// File: rtl/event_fifo_reader.sv
`default_nettype none
// ============================================================================
//  Module   : event_fifo_reader
//  Purpose  : Read side of the capture event FIFO. Pops 64-bit sample words
//             from a standard-mode FIFO (1-cycle read latency) and emits each
//             word as two 32-bit AXI-Stream beats, low half first. tlast marks
//             the final beat of every EVENT_WORDS-word event. The reader is
//             armed/disarmed by the shared 8-bit cmd bus; a disarm only takes
//             effect at an event boundary.
//  Ports    : f125_clk, reset        - clock, synchronous active-high reset
//             cmd                    - command bus (CMD_START / CMD_STOP)
//             dout_i, empty_i        - FIFO read data and empty flag
//             rd_en_o                - FIFO pop strobe (single-cycle pulse)
//             m_axis_t*              - 32-bit AXI-Stream master
//             armed_o                - reader armed
//             event_count_o          - completed events since reset (wraps)
//  Options  : EVENT_HEADER_EN - when defined, each event is prefixed with one
//             header beat {16'hE7E7, event_count_o[15:0]}.
//  Revision : 1.0 - initial release
// ============================================================================
module event_fifo_reader #(
    parameter int unsigned EVENT_WORDS = 64,
    parameter logic [7:0]  CMD_START   = 8'h01,
    parameter logic [7:0]  CMD_STOP    = 8'h02
) (
    input  logic        f125_clk,
    input  logic        reset,
    input  logic [7:0]  cmd,
    input  logic [63:0] dout_i,
    input  logic        empty_i,
    output logic        rd_en_o,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        armed_o,
    output logic [31:0] event_count_o
);

    localparam logic [2:0]  c_ST_IDLE    = 3'd0;
    localparam logic [2:0]  c_ST_FETCH   = 3'd1;
    localparam logic [2:0]  c_ST_WAIT    = 3'd2;
    localparam logic [2:0]  c_ST_SEND_LO = 3'd3;
    localparam logic [2:0]  c_ST_SEND_HI = 3'd4;
    localparam logic [2:0]  c_ST_HDR     = 3'd5;

    localparam logic [15:0] c_LAST_WORD  = 16'(EVENT_WORDS - 1);
    localparam logic [15:0] c_HDR_TAG    = 16'hE7E7;

    logic [2:0]  r_state;
    logic        r_armed;
    logic [15:0] r_word_cnt;
    logic [63:0] r_hold;
    logic [31:0] r_tdata;
    logic        r_tvalid;
    logic        r_tlast;
    logic [31:0] r_event_cnt;
`ifdef EVENT_HEADER_EN
    // High during the first HDR cycle: the popped word is on dout_i only then
    // is it guaranteed to be the one we asked for, so it is captured once.
    logic        r_hdr_first;
`endif

    logic w_at_boundary;
    logic w_park;
    logic w_pop;
    logic w_handshake;
    logic w_last_word;

    assign w_at_boundary = (r_word_cnt == 16'd0);
    // Disarm only parks the reader between events, never inside one.
    assign w_park        = !r_armed && w_at_boundary;
    // The pop strobe is decoded from the registered state so it lasts exactly
    // the FETCH cycle and can never be raised against an empty FIFO.
    assign w_pop         = (r_state == c_ST_FETCH) && !w_park && !empty_i;
    assign w_handshake   = r_tvalid && m_axis_tready;
    assign w_last_word   = (r_word_cnt == c_LAST_WORD);

    assign rd_en_o       = w_pop;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tlast;
    assign armed_o       = r_armed;
    assign event_count_o = r_event_cnt;

    always_ff @(posedge f125_clk) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_armed     <= 1'b0;
            r_word_cnt  <= 16'd0;
            r_hold      <= 64'd0;
            r_tdata     <= 32'd0;
            r_tvalid    <= 1'b0;
            r_tlast     <= 1'b0;
            r_event_cnt <= 32'd0;
`ifdef EVENT_HEADER_EN
            r_hdr_first <= 1'b0;
`endif
        end else begin
            if (cmd == CMD_START) begin
                r_armed <= 1'b1;
            end else if (cmd == CMD_STOP) begin
                r_armed <= 1'b0;
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (r_armed) begin
                        r_state <= c_ST_FETCH;
                    end
                end

                c_ST_FETCH: begin
                    if (w_park) begin
                        r_state <= c_ST_IDLE;
                    end else if (!empty_i) begin
`ifdef EVENT_HEADER_EN
                        if (w_at_boundary) begin
                            r_state     <= c_ST_HDR;
                            r_tdata     <= {c_HDR_TAG, r_event_cnt[15:0]};
                            r_tvalid    <= 1'b1;
                            r_tlast     <= 1'b0;
                            r_hdr_first <= 1'b1;
                        end else begin
                            r_state <= c_ST_WAIT;
                        end
`else
                        r_state <= c_ST_WAIT;
`endif
                    end
                end

                c_ST_WAIT: begin
                    r_hold   <= dout_i;
                    r_tdata  <= dout_i[31:0];
                    r_tvalid <= 1'b1;
                    r_tlast  <= 1'b0;
                    r_state  <= c_ST_SEND_LO;
                end

`ifdef EVENT_HEADER_EN
                c_ST_HDR: begin
                    r_hdr_first <= 1'b0;
                    if (r_hdr_first) begin
                        r_hold <= dout_i;
                    end
                    if (w_handshake) begin
                        // Header may be accepted in its very first cycle,
                        // before r_hold has been loaded.
                        r_tdata <= r_hdr_first ? dout_i[31:0] : r_hold[31:0];
                        r_state <= c_ST_SEND_LO;
                    end
                end
`endif

                c_ST_SEND_LO: begin
                    if (w_handshake) begin
                        r_tdata <= r_hold[63:32];
                        r_tlast <= w_last_word;
                        r_state <= c_ST_SEND_HI;
                    end
                end

                c_ST_SEND_HI: begin
                    if (w_handshake) begin
                        r_tvalid <= 1'b0;
                        r_tlast  <= 1'b0;
                        r_state  <= c_ST_FETCH;
                        if (w_last_word) begin
                            r_word_cnt  <= 16'd0;
                            r_event_cnt <= r_event_cnt + 32'd1;
                        end else begin
                            r_word_cnt <= r_word_cnt + 16'd1;
                        end
                    end
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_event_fifo_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_event_fifo_reader
//  Purpose  : Directed self-checking bench for event_fifo_reader. A 64-word
//             event instance and a 2-word event instance share clock, reset,
//             cmd and tready; each has its own FIFO model and beat recorder.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_event_fifo_reader;

    localparam int c_EW = 64;
`ifdef EVENT_HEADER_EN
    localparam int c_HDR = 1;
`else
    localparam int c_HDR = 0;
`endif
    localparam int c_BPE = 2 * c_EW + c_HDR;
    localparam logic [7:0] c_START = 8'h01;
    localparam logic [7:0] c_STOP  = 8'h02;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  cmd = 8'h00;
    logic        tready = 1'b1;

    logic [63:0] dout = 64'd0;
    logic        empty;
    logic        rd_en;
    logic [31:0] tdata;
    logic        tvalid, tlast, armed;
    logic [31:0] evcnt;

    logic [63:0] s_dout = 64'd0;
    logic        s_empty;
    logic        s_rd_en;
    logic [31:0] s_tdata;
    logic        s_tvalid, s_tlast, s_armed;
    logic [31:0] s_evcnt;

    int checks = 0;
    int failures = 0;

    always #4 clk = ~clk;

    event_fifo_reader #(.EVENT_WORDS(c_EW), .CMD_START(c_START), .CMD_STOP(c_STOP)) dut (
        .f125_clk(clk), .reset(reset), .cmd(cmd), .dout_i(dout), .empty_i(empty),
        .rd_en_o(rd_en), .m_axis_tdata(tdata), .m_axis_tvalid(tvalid),
        .m_axis_tready(tready), .m_axis_tlast(tlast), .armed_o(armed),
        .event_count_o(evcnt)
    );

    event_fifo_reader #(.EVENT_WORDS(2), .CMD_START(c_START), .CMD_STOP(c_STOP)) dut_small (
        .f125_clk(clk), .reset(reset), .cmd(cmd), .dout_i(s_dout), .empty_i(s_empty),
        .rd_en_o(s_rd_en), .m_axis_tdata(s_tdata), .m_axis_tvalid(s_tvalid),
        .m_axis_tready(tready), .m_axis_tlast(s_tlast), .armed_o(s_armed),
        .event_count_o(s_evcnt)
    );

    // ---------------- FIFO models (1-cycle read latency) ----------------
    logic [63:0] mem [0:511];
    int push_cnt = 0;
    int pop_cnt = 0;
    assign empty = (push_cnt == pop_cnt);
    always @(posedge clk) begin
        if (rd_en) begin
            dout    <= mem[pop_cnt];
            pop_cnt <= pop_cnt + 1;
        end
    end

    logic [63:0] s_mem [0:7];
    int s_push = 0;
    int s_pop = 0;
    assign s_empty = (s_push == s_pop);
    always @(posedge clk) begin
        if (s_rd_en) begin
            s_dout <= s_mem[s_pop];
            s_pop  <= s_pop + 1;
        end
    end

    // ---------------- Beat recorders (sampled on falling edge) ----------------
    logic [31:0] b_data [0:1023];
    logic        b_last [0:1023];
    int b_n = 0;
    int last_n = 0;
    int rd_n = 0;
    int rd_empty_err = 0;
    int stall_err = 0;
    logic        p_stall = 1'b0;
    logic [31:0] p_data = 32'd0;
    logic        p_last = 1'b0;

    always @(negedge clk) begin
        if (tvalid && tready) begin
            b_data[b_n] <= tdata;
            b_last[b_n] <= tlast;
            b_n <= b_n + 1;
            if (tlast) last_n <= last_n + 1;
        end
        if (rd_en) rd_n <= rd_n + 1;
        if (rd_en && empty) rd_empty_err <= rd_empty_err + 1;
        if (p_stall && (!tvalid || tdata !== p_data || tlast !== p_last))
            stall_err <= stall_err + 1;
        p_stall <= tvalid && !tready;
        p_data  <= tdata;
        p_last  <= tlast;
    end

    logic [31:0] s_b_data [0:7];
    logic        s_b_last [0:7];
    int s_b_n = 0;
    always @(negedge clk) begin
        if (s_tvalid && tready && s_b_n < 8) begin
            s_b_data[s_b_n] <= s_tdata;
            s_b_last[s_b_n] <= s_tlast;
            s_b_n <= s_b_n + 1;
        end
    end

    // ---------------- Helpers ----------------
    function automatic logic [63:0] word_of(input int n);
        return {8'h5A, 24'(2 * n + 1), 8'hA5, 24'(2 * n)};
    endfunction

    // Expected {tlast, tdata} for global beat index gb of the 64-word instance.
    function automatic logic [32:0] exp_beat(input int gb);
        int e;
        int r;
        logic [63:0] w;
        e = gb / c_BPE;
        r = gb % c_BPE;
`ifdef EVENT_HEADER_EN
        if (r == 0) return {1'b0, 16'hE7E7, 16'(e)};
        r = r - 1;
`endif
        w = word_of(e * c_EW + r / 2);
        if (r % 2 == 1) return {(r == 2 * c_EW - 1), w[63:32]};
        return {1'b0, w[31:0]};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_words(input int first, input int last);
        for (int n = first; n <= last; n++) begin
            mem[push_cnt] = word_of(n);
            push_cnt = push_cnt + 1;
        end
    endtask

    // ---------------- Tests ----------------
    task automatic test_reset;
        cmd = 8'h00;
        tready = 1'b1;
        reset = 1'b1;
        push_words(0, 7);
        tick(5);
        checks++;
        if ({tvalid, tlast, armed, rd_en, tdata, evcnt} !== 68'd0) begin
            failures++;
            $display("FAIL reset_outputs got tvalid=%b tlast=%b armed=%b rd_en=%b tdata=%h evcnt=%0d want all 0",
                     tvalid, tlast, armed, rd_en, tdata, evcnt);
        end
        reset = 1'b0;
        tick(100);
        checks++;
        if (rd_n !== 0) begin
            failures++;
            $display("FAIL idle_no_rd_en got %0d pulses want 0", rd_n);
        end
        checks++;
        if (b_n !== 0 || tvalid !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_tvalid got beats=%0d tvalid=%b want 0/0", b_n, tvalid);
        end
        checks++;
        if (evcnt !== 32'd0 || armed !== 1'b0) begin
            failures++;
            $display("FAIL idle_state got evcnt=%0d armed=%b want 0/0", evcnt, armed);
        end
    endtask

    task automatic test_two_word_event;
        logic [31:0] exp_d [0:3];
        int n;
        exp_d[0] = 32'h3333_4444;
        exp_d[1] = 32'h1111_2222;
        exp_d[2] = 32'h7777_8888;
        exp_d[3] = 32'h5555_6666;
        s_mem[0] = 64'h1111_2222_3333_4444;
        s_mem[1] = 64'h5555_6666_7777_8888;
        s_push = 2;
        cmd = c_START;
        tick(1);
        cmd = 8'h00;
        checks++;
        if (armed !== 1'b1 || s_armed !== 1'b1) begin
            failures++;
            $display("FAIL arm_start got armed=%b small_armed=%b want 1/1", armed, s_armed);
        end
        n = 0;
        while (s_evcnt !== 32'd1 && n < 200) begin
            tick(1);
            n++;
        end
        checks++;
        if (s_evcnt !== 32'd1) begin
            failures++;
            $display("FAIL ew2_event_count got %0d want 1", s_evcnt);
        end
        checks++;
        if (s_b_n !== 4 + c_HDR) begin
            failures++;
            $display("FAIL ew2_beat_count got %0d want %0d", s_b_n, 4 + c_HDR);
        end
`ifdef EVENT_HEADER_EN
        checks++;
        if (s_b_data[0] !== 32'hE7E7_0000 || s_b_last[0] !== 1'b0) begin
            failures++;
            $display("FAIL ew2_header got %h/%b want e7e70000/0", s_b_data[0], s_b_last[0]);
        end
`endif
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (s_b_data[c_HDR + i] !== exp_d[i] || s_b_last[c_HDR + i] !== (i == 3)) begin
                failures++;
                $display("FAIL ew2_beat%0d got %h/%b want %h/%b", i,
                         s_b_data[c_HDR + i], s_b_last[c_HDR + i], exp_d[i], (i == 3));
            end
        end
    endtask

    task automatic test_random_tready;
        int n;
        logic [32:0] e;
        push_words(8, 63);
        n = 0;
        while (evcnt !== 32'd1 && n < 5000) begin
            tready = ($urandom_range(0, 99) < 30);
            tick(1);
            n++;
        end
        tready = 1'b1;
        checks++;
        if (evcnt !== 32'd1) begin
            failures++;
            $display("FAIL rand_event_count got %0d want 1", evcnt);
        end
        checks++;
        if (b_n !== c_BPE || last_n !== 1 || b_last[c_BPE - 1] !== 1'b1) begin
            failures++;
            $display("FAIL rand_beats got beats=%0d tlasts=%0d want %0d/1", b_n, last_n, c_BPE);
        end
        checks++;
        if (stall_err !== 0) begin
            failures++;
            $display("FAIL rand_stall_stable got %0d violations want 0", stall_err);
        end
        for (int gb = 0; gb < c_BPE; gb++) begin
            e = exp_beat(gb);
            checks++;
            if ({b_last[gb], b_data[gb]} !== e) begin
                failures++;
                $display("FAIL rand_beat%0d got %b/%h want %b/%h", gb, b_last[gb], b_data[gb], e[32], e[31:0]);
            end
        end
    endtask

    task automatic test_fifo_gap;
        int n;
        int tv_hi;
        int rd_hi;
        logic [32:0] e;
        push_words(64, 73);
        n = 0;
        while (pop_cnt < 74 && n < 500) begin
            tick(1);
            n++;
        end
        tick(10);
        tv_hi = 0;
        rd_hi = 0;
        repeat (40) begin
            @(negedge clk);
            if (tvalid) tv_hi++;
            if (rd_en) rd_hi++;
        end
        tick(1);
        checks++;
        if (tv_hi !== 0 || rd_hi !== 0 || pop_cnt !== 74) begin
            failures++;
            $display("FAIL gap_quiet got tvalid_cycles=%0d rd_en_cycles=%0d pops=%0d want 0/0/74",
                     tv_hi, rd_hi, pop_cnt);
        end
        push_words(74, 127);
        n = 0;
        while (evcnt !== 32'd2 && n < 2000) begin
            tick(1);
            n++;
        end
        checks++;
        if (evcnt !== 32'd2 || b_n !== 2 * c_BPE || last_n !== 2) begin
            failures++;
            $display("FAIL gap_event got evcnt=%0d beats=%0d tlasts=%0d want 2/%0d/2",
                     evcnt, b_n, last_n, 2 * c_BPE);
        end
        checks++;
        if (rd_empty_err !== 0) begin
            failures++;
            $display("FAIL rd_en_while_empty got %0d want 0", rd_empty_err);
        end
        for (int gb = c_BPE; gb < 2 * c_BPE; gb++) begin
            e = exp_beat(gb);
            checks++;
            if ({b_last[gb], b_data[gb]} !== e) begin
                failures++;
                $display("FAIL gap_beat%0d got %b/%h want %b/%h", gb, b_last[gb], b_data[gb], e[32], e[31:0]);
            end
        end
    endtask

    task automatic test_stop_mid_event;
        int n;
        int rd_base;
        push_words(128, 191);
        n = 0;
        while (pop_cnt < 148 && n < 500) begin
            tick(1);
            n++;
        end
        cmd = c_STOP;
        tick(1);
        cmd = 8'h00;
        checks++;
        if (armed !== 1'b0) begin
            failures++;
            $display("FAIL stop_disarm got armed=%b want 0", armed);
        end
        n = 0;
        while (evcnt !== 32'd3 && n < 2000) begin
            tick(1);
            n++;
        end
        checks++;
        if (evcnt !== 32'd3 || b_n !== 3 * c_BPE || last_n !== 3 || b_last[3 * c_BPE - 1] !== 1'b1) begin
            failures++;
            $display("FAIL stop_event_completes got evcnt=%0d beats=%0d tlasts=%0d want 3/%0d/3",
                     evcnt, b_n, last_n, 3 * c_BPE);
        end
        tick(5);
        rd_base = rd_n;
        push_words(192, 199);
        tick(100);
        checks++;
        if (rd_n !== rd_base || pop_cnt !== 192 || tvalid !== 1'b0) begin
            failures++;
            $display("FAIL stop_no_fetch got rd_pulses=%0d pops=%0d tvalid=%b want %0d/192/0",
                     rd_n, pop_cnt, tvalid, rd_base);
        end
    endtask

    task automatic test_restart;
        int n;
        logic [63:0] w;
        logic [32:0] e;
        cmd = c_START;
        tick(1);
        cmd = 8'h00;
        checks++;
        if (armed !== 1'b1) begin
            failures++;
            $display("FAIL restart_arm got armed=%b want 1", armed);
        end
        n = 0;
        while (b_n < 3 * c_BPE + c_HDR + 2 && n < 200) begin
            tick(1);
            n++;
        end
        w = word_of(192);
        checks++;
        if (b_data[3 * c_BPE + c_HDR] !== w[31:0] || b_data[3 * c_BPE + c_HDR + 1] !== w[63:32]) begin
            failures++;
            $display("FAIL restart_next_word got %h %h want %h %h", b_data[3 * c_BPE + c_HDR],
                     b_data[3 * c_BPE + c_HDR + 1], w[31:0], w[63:32]);
        end
        push_words(200, 255);
        n = 0;
        while (evcnt !== 32'd4 && n < 2000) begin
            tick(1);
            n++;
        end
        checks++;
        if (evcnt !== 32'd4 || last_n !== 4 || b_n !== 4 * c_BPE) begin
            failures++;
            $display("FAIL restart_event got evcnt=%0d tlasts=%0d beats=%0d want 4/4/%0d",
                     evcnt, last_n, b_n, 4 * c_BPE);
        end
        for (int gb = 3 * c_BPE; gb < 4 * c_BPE; gb++) begin
            e = exp_beat(gb);
            checks++;
            if ({b_last[gb], b_data[gb]} !== e) begin
                failures++;
                $display("FAIL restart_beat%0d got %b/%h want %b/%h", gb, b_last[gb], b_data[gb], e[32], e[31:0]);
            end
        end
    endtask

`ifdef EVENT_HEADER_EN
    task automatic test_header;
        checks++;
        if (b_data[0] !== 32'hE7E7_0000 || b_last[0] !== 1'b0) begin
            failures++;
            $display("FAIL header_ev0 got %h/%b want e7e70000/0", b_data[0], b_last[0]);
        end
        checks++;
        if (b_data[c_BPE] !== 32'hE7E7_0001 || b_last[c_BPE] !== 1'b0) begin
            failures++;
            $display("FAIL header_ev1 got %h/%b want e7e70001/0", b_data[c_BPE], b_last[c_BPE]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_two_word_event();
        test_random_tready();
        test_fifo_gap();
        test_stop_mid_event();
        test_restart();
`ifdef EVENT_HEADER_EN
        test_header();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/event_fifo_reader.md
Name: event_fifo_reader

Overview:
- Read side of the capture event FIFO. Pops 64-bit sample words (standard-mode FIFO, 1-cycle read latency) and emits them as a 32-bit AXI-Stream toward the DMA/readout path.
- Emits the low half of each word first, then the high half.
- Marks event boundaries with tlast after EVENT_WORDS words.
- Armed and disarmed by the same 8-bit cmd bus that drives the capture side.

Parameters:
- EVENT_WORDS, 64: 64-bit FIFO words per event; legal range 1..65535.
- CMD_START, 8'h01: cmd value that arms the reader.
- CMD_STOP, 8'h02: cmd value that disarms the reader.

Ports:
- f125_clk  input  1  system clock; everything is sampled on the rising edge.
- reset  input  1  synchronous, active-high reset.
- cmd  input  8  command bus; compared each cycle against CMD_START and CMD_STOP.
- dout_i  input  64  FIFO read data; valid in the cycle after rd_en_o is asserted.
- empty_i  input  1  FIFO empty flag.
- rd_en_o  output  1  FIFO pop strobe; single-cycle pulse.
- m_axis_tdata  output  32  stream data.
- m_axis_tvalid  output  1  stream valid.
- m_axis_tready  input  1  stream ready.
- m_axis_tlast  output  1  last beat of an event.
- armed_o  output  1  high while the reader is armed.
- event_count_o  output  32  events fully sent since reset; wraps at 2^32.

Behaviour:
- Reset (while reset=1 at a clock edge):
  - State goes to IDLE.
  - rd_en_o=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, armed_o=0, event_count_o=0.
  - Word counter and holding register cleared.
  - Reset mid-event abandons the event: no tlast, no count increment.
- Arming:
  - cmd==CMD_START sets armed_o on the next edge.
  - cmd==CMD_STOP clears armed_o on the next edge.
  - Disarm takes effect only at an event boundary: a started event always completes, including its tlast.
  - Any other cmd value is ignored.
- States:
  - IDLE: goes to FETCH when armed_o=1.
  - FETCH:
    - If armed_o=0 and word counter==0, go to IDLE.
    - Else if empty_i=0: assert rd_en_o for exactly this cycle, then go to WAIT.
    - Else (empty_i=1): stay in FETCH with rd_en_o=0.
  - WAIT: capture dout_i into the 64-bit holding register, then go to SEND_LO.
  - SEND_LO:
    - m_axis_tvalid=1, tdata=hold[31:0], tlast=0.
    - On tvalid&&tready, go to SEND_HI.
  - SEND_HI:
    - m_axis_tvalid=1, tdata=hold[63:32].
    - tlast=1 when word counter==EVENT_WORDS-1.
    - On handshake: if this was the last word, clear the counter, increment event_count_o, and go to FETCH. Otherwise increment the counter and go to FETCH.
- Stream rules:
  - Registered outputs.
  - tdata and tlast are held stable while tvalid=1 and tready=0.
  - tvalid never drops without a handshake.
- Ordering and throughput:
  - rd_en_o is never asserted while empty_i=1.
  - At most one FIFO word is outstanding.
  - Minimum 4 cycles per word (FETCH, WAIT, LO, HI) when tready=1 and the FIFO is non-empty.
- Boundary conditions:
  - FIFO empties mid-event: stall in FETCH with tvalid=0; resume with no data loss.
  - CMD_START and CMD_STOP are mutually exclusive by encoding, so they cannot arrive together.
  - cmd==CMD_STOP while already in IDLE: no effect.
  - EVENT_WORDS=1: tlast on every SEND_HI beat.

Optional Feature:
- Macro: EVENT_HEADER_EN.
- Defined:
  - A state HDR is inserted between FETCH and the first word of each event, entered only when the word counter==0 and a word has been popped.
  - HDR emits one extra beat with tdata={16'hE7E7, event_count_o[15:0]} and tlast=0.
  - The popped word is captured during HDR and is sent after the header handshake.
  - Beats per event = 2*EVENT_WORDS+1.
- Undefined: no header; beats per event = 2*EVENT_WORDS.

Test Plan:
- Reset with a non-empty FIFO, tready=1, then reset released with no command: rd_en_o stays 0 and tvalid stays 0 for 100 cycles; event_count_o=0.
- EVENT_WORDS=2, FIFO preloaded with 64'h1111_2222_3333_4444 and 64'h5555_6666_7777_8888, CMD_START pulsed:
  - Beats are 3333_4444, 1111_2222, 7777_8888, 5555_6666.
  - tlast only on 5555_6666.
  - event_count_o=1.
- Random tready at 30% duty during a 64-word event: every beat is stable while stalled, no beat is duplicated or lost, and there are exactly 128 beats with a single tlast.
- FIFO runs empty after word 10 of 64, then refills after 50 cycles: tvalid=0 during the gap, rd_en_o=0 while empty_i=1, and the event completes correctly.
- CMD_STOP issued mid-event: the event finishes with tlast, armed_o=0, and no further rd_en_o despite empty_i=0. A following CMD_START resumes with the next word.
- EVENT_HEADER_EN defined, two events: the first beat of each event is E7E7_0000, then E7E7_0001; each event is 129 beats for EVENT_WORDS=64.
